// File: rtl/vpu_pkg.sv
// Shared definitions for the vector-op sequencer.
//  - state_e     : sequencer FSM state encoding
//  - F7_*        : supported vector funct7 values
//  - VALU_*      : lane ALU operation select codes
//  - VEC_OPCODE  : major opcode of vector instructions (decoded upstream)
//  - is_arith / arith_sel : funct7 classification helpers
package vpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [6:0] VEC_OPCODE = 7'b1111111;

    localparam logic [6:0] F7_VLD  = 7'b0000001;
    localparam logic [6:0] F7_VADD = 7'b0000000;
    localparam logic [6:0] F7_VSUB = 7'b0100000;
    localparam logic [6:0] F7_VMUL = 7'b1100000;

    localparam logic [2:0] VALU_ADD = 3'd0;
    localparam logic [2:0] VALU_SUB = 3'd1;
    localparam logic [2:0] VALU_MUL = 3'd2;

    function automatic logic is_arith(input logic [6:0] f7);
        return (f7 == F7_VADD) || (f7 == F7_VSUB) || (f7 == F7_VMUL);
    endfunction

    function automatic logic [2:0] arith_sel(input logic [6:0] f7);
        logic [2:0] sel;
        sel = VALU_ADD;
        if (f7 == F7_VSUB) sel = VALU_SUB;
        if (f7 == F7_VMUL) sel = VALU_MUL;
        return sel;
    endfunction

endpackage

// File: rtl/vec_lane_mask.sv
// Combinational lane-enable mask generator.
//  vlr  : vector length (number of active elements)
//  mask : thermometer mask, bit i set when lane i < vlr. Lengths beyond LANES
//         naturally saturate to all-ones, so no separate clamp is needed.
module vec_lane_mask #(
    parameter int LANES = 8
) (
    input  logic [31:0]      vlr,
    output logic [LANES-1:0] mask
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign mask[gi] = (vlr > 32'(gi));
        end
    endgenerate

endmodule

// File: rtl/vec_op_sequencer.sv
// Multi-cycle sequencer for vector instructions. Stalls the scalar PC while a
// vector op runs and steps load/store, operand read, lane ALU and write-back
// through their done handshakes. Every enable is registered and asserted in
// exactly the cycle its state is active.
//  Inputs : clk, rst_n (async, active low), vec_valid, funct7, vlr,
//           vls_done, vrb_done, vrw_done
//  Outputs: stall_pc (combinational), vls_enable, load_store, vreg_write,
//           sel_start, valu_sel, valu_ena, vrw_ena, busy, illegal, timeout
module vec_op_sequencer
    import vpu_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_valid,
    input  logic [6:0]       funct7,
    input  logic [31:0]      vlr,
    input  logic             vls_done,
    input  logic             vrb_done,
    input  logic             vrw_done,
    output logic             stall_pc,
    output logic             vls_enable,
    output logic             load_store,
    output logic             vreg_write,
    output logic             sel_start,
    output logic [2:0]       valu_sel,
    output logic [LANES-1:0] valu_ena,
    output logic             vrw_ena,
    output logic             busy,
    output logic             illegal,
    output logic             timeout
);

    localparam logic [CNT_W:0] TIMEOUT_W = (CNT_W + 1)'(TIMEOUT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       vlr_q, vlr_d;
    logic [2:0]        valu_sel_q, valu_sel_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              vls_enable_q, vls_enable_d;
    logic              sel_start_q, sel_start_d;
    logic [LANES-1:0]  valu_ena_q, valu_ena_d;
    logic              vrw_ena_q, vrw_ena_d;

    logic [LANES-1:0]  lane_mask;
    logic [CNT_W:0]    cnt_cur;
    logic              expired;

    vec_lane_mask #(.LANES(LANES)) u_lane_mask (
        .vlr  (vlr_q),
        .mask (lane_mask)
    );

    // cnt_q holds the cycles already completed in the waiting state, so
    // cnt_cur is the 1-based number of the current cycle. Expiry fires in
    // cycle TIMEOUT; a done sampled in that same cycle takes priority.
    assign cnt_cur = {1'b0, cnt_q} + 1'b1;
    assign expired = (TIMEOUT != 0) && (cnt_cur == TIMEOUT_W);

    // State register and all output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            vlr_q        <= '0;
            valu_sel_q   <= '0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            vls_enable_q <= 1'b0;
            sel_start_q  <= 1'b0;
            valu_ena_q   <= '0;
            vrw_ena_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vlr_q        <= vlr_d;
            valu_sel_q   <= valu_sel_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            vls_enable_q <= vls_enable_d;
            sel_start_q  <= sel_start_d;
            valu_ena_q   <= valu_ena_d;
            vrw_ena_q    <= vrw_ena_d;
        end
    end

    // Next-state logic, operand capture and watchdog
    always_comb begin
        state_d    = state_q;
        vlr_d      = vlr_q;
        valu_sel_d = valu_sel_q;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;
        cnt_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (vec_valid) begin
                    vlr_d = vlr;
                    if (funct7 == F7_VLD) begin
                        state_d = S_LOAD;
                    end else if (is_arith(funct7)) begin
                        valu_sel_d = arith_sel(funct7);
                        // Zero-length arithmetic completes as a no-op
                        state_d    = (vlr == 32'd0) ? S_DONE : S_READ;
                    end else begin
                        state_d   = S_DONE;
                        illegal_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (vls_done) begin
                    state_d = S_DONE;
                end else if (expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_READ: begin
                if (vrb_done) begin
                    state_d = S_EXEC;
                end else if (expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: begin
                if (vrw_done) begin
                    state_d = S_DONE;
                end else if (expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Counter restarts on every state entry and only runs while a
        // waiting state is held.
        if ((state_d == state_q) &&
            (state_d == S_LOAD || state_d == S_READ || state_d == S_WRITE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output decode from the upcoming state so the registered enables line
    // up with the cycle the state is active.
    always_comb begin
        vls_enable_d = (state_d == S_LOAD);
        sel_start_d  = (state_d == S_READ);
        valu_ena_d   = (state_d == S_EXEC) ? lane_mask : '0;
        vrw_ena_d    = (state_d == S_WRITE);
    end

    // The PC is released in DONE so the next instruction is presented to
    // IDLE rather than the one just completed.
    assign stall_pc   = ((state_q == S_IDLE) && vec_valid) ||
                        ((state_q != S_IDLE) && (state_q != S_DONE));
    assign busy       = (state_q != S_IDLE);
    assign vls_enable = vls_enable_q;
    assign load_store = vls_enable_q;
    assign vreg_write = vls_enable_q;
    assign sel_start  = sel_start_q;
    assign valu_sel   = valu_sel_q;
    assign valu_ena   = valu_ena_q;
    assign vrw_ena    = vrw_ena_q;
    assign illegal    = illegal_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_vec_op_sequencer.sv
module tb_vec_op_sequencer;
    import vpu_pkg::*;

    localparam int LANES = 8;
    localparam int TMO   = 4;

    logic             clk;
    logic             rst_n;
    logic             vec_valid;
    logic [6:0]       funct7;
    logic [31:0]      vlr;
    logic             vls_done, vrb_done, vrw_done;
    logic             stall_pc, vls_enable, load_store, vreg_write, sel_start;
    logic [2:0]       valu_sel;
    logic [LANES-1:0] valu_ena;
    logic             vrw_ena, busy, illegal, timeout;

    int checks   = 0;
    int failures = 0;

    vec_op_sequencer #(.LANES(LANES), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vec_valid  (vec_valid),
        .funct7     (funct7),
        .vlr        (vlr),
        .vls_done   (vls_done),
        .vrb_done   (vrb_done),
        .vrw_done   (vrw_done),
        .stall_pc   (stall_pc),
        .vls_enable (vls_enable),
        .load_store (load_store),
        .vreg_write (vreg_write),
        .sel_start  (sel_start),
        .valu_sel   (valu_sel),
        .valu_ena   (valu_ena),
        .vrw_ena    (vrw_ena),
        .busy       (busy),
        .illegal    (illegal),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundle: {stall,busy,vls,ls,vw,sel_start,vrw,ill,tmo,ena[7:0]}
    logic [16:0] obs;
    assign obs = {stall_pc, busy, vls_enable, load_store, vreg_write, sel_start,
                  vrw_ena, illegal, timeout, valu_ena};

    // One expected cycle of an operation. waits: 0 none, 1 vls, 2 vrb, 3 vrw
    typedef struct {
        logic        vv;
        int          waits;
        logic        hit;
        logic [16:0] exp;
        logic        chk_sel;
        logic [2:0]  sel;
    } cyc_t;

    cyc_t sched[$];

    function automatic logic [16:0] pk(input logic st, input logic bz, input logic vls,
                                       input logic sel, input logic vrw, input logic ill,
                                       input logic tmo, input logic [7:0] ena);
        return {st, bz, vls, vls, vls, sel, vrw, ill, tmo, ena};
    endfunction

    task automatic push(input logic vv, input int waits, input logic hit,
                        input logic [16:0] e, input logic chk, input logic [2:0] s);
        cyc_t c;
        c.vv = vv; c.waits = waits; c.hit = hit; c.exp = e; c.chk_sel = chk; c.sel = s;
        sched.push_back(c);
    endtask

    // A waiting phase lasts until its done (cycle d, 1-based) or TMO cycles.
    task automatic add_wait(input int kind, input int d, output logic to);
        logic ok;
        int   n;
        ok = (d >= 1) && (d <= TMO);
        n  = ok ? d : TMO;
        for (int k = 1; k <= n; k++) begin
            push(1'b1, kind, ok && (k == d),
                 pk(1'b1, 1'b1, kind == 1, kind == 2, kind == 3, 1'b0, 1'b0, 8'h00),
                 1'b0, 3'd0);
        end
        to = !ok;
    endtask

    task automatic run_op(input string name, input logic [6:0] f, input logic [31:0] v,
                          input int d_ls, input int d_rb, input int d_rw, input bit gap);
        logic       ill, to;
        logic [7:0] ena;
        logic [2:0] s;
        sched.delete();
        ill = 1'b0;
        to  = 1'b0;
        push(1'b1, 0, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), 1'b0, 3'd0);
        if (f == F7_VLD) begin
            add_wait(1, d_ls, to);
        end else if (f == F7_VADD || f == F7_VSUB || f == F7_VMUL) begin
            if (v != 0) begin
                add_wait(2, d_rb, to);
                if (!to) begin
                    ena = (v >= LANES) ? 8'hFF : 8'((1 << v) - 1);
                    s   = (f == F7_VADD) ? 3'd0 : (f == F7_VSUB) ? 3'd1 : 3'd2;
                    push(1'b1, 0, 1'b0, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ena), 1'b1, s);
                    add_wait(3, d_rw, to);
                end
            end
        end else begin
            ill = 1'b1;
        end
        // DONE: instruction still presented, PC released
        push(1'b1, 0, 1'b0, pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ill, to, 8'h00), 1'b0, 3'd0);
        if (gap)
            push(1'b0, 0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), 1'b0, 3'd0);

        for (int i = 0; i < sched.size(); i++) begin
            vec_valid = sched[i].vv;
            funct7    = (i == 0) ? f : 7'($urandom);
            vlr       = (i == 0) ? v : $urandom;
            vls_done  = (sched[i].waits == 1) ? sched[i].hit : 1'($urandom);
            vrb_done  = (sched[i].waits == 2) ? sched[i].hit : 1'($urandom);
            vrw_done  = (sched[i].waits == 3) ? sched[i].hit : 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs !== sched[i].exp) begin
                failures++;
                $display("FAIL %s cyc%0d outputs got=%h exp=%h", name, i, obs, sched[i].exp);
            end
            if (sched[i].chk_sel) begin
                checks++;
                if (valu_sel !== sched[i].sel) begin
                    failures++;
                    $display("FAIL %s valu_sel got=%0d exp=%0d", name, valu_sel, sched[i].sel);
                end
            end
            @(posedge clk);
            #1;
        end
        $display("op %s f7=%b vlr=%0d cycles=%0d ill=%0b tmo=%0b",
                 name, f, v, sched.size(), ill, to);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vec_valid = 1'b0; funct7 = '0; vlr = '0;
        vls_done = 1'b0; vrb_done = 1'b0; vrw_done = 1'b0;
        #3;
        checks++;
        if (obs !== 17'h0 || valu_sel !== 3'd0) begin
            failures++;
            $display("FAIL reset_hold outputs got=%h sel=%0d exp=0", obs, valu_sel);
        end
        #9 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 17'h0) begin
            failures++;
            $display("FAIL reset_release outputs got=%h exp=0", obs);
        end
        @(posedge clk);
        #1;
        $display("op reset");
    endtask

    task automatic test_load();
        run_op("load", F7_VLD, 32'd7, 3, 0, 0, 1'b1);
    endtask

    task automatic test_add();
        run_op("add5", F7_VADD, 32'd5, 0, 2, 1, 1'b1);
    endtask

    task automatic test_mul_clamp();
        run_op("mul12", F7_VMUL, 32'd12, 0, 1, 2, 1'b1);
        run_op("sub8", F7_VSUB, 32'd8, 0, 3, 3, 1'b1);
        run_op("mul_vlr0", F7_VMUL, 32'd0, 0, 1, 1, 1'b1);
    endtask

    task automatic test_illegal();
        run_op("illegal", 7'b0000011, 32'd4, 0, 0, 0, 1'b1);
    endtask

    task automatic test_timeout();
        run_op("read_tmo", F7_VADD, 32'd3, 0, TMO + 1, 1, 1'b1);
        run_op("read_done_at_tmo", F7_VADD, 32'd3, 0, TMO, 1, 1'b1);
        run_op("load_tmo", F7_VLD, 32'd1, TMO + 2, 0, 0, 1'b1);
        run_op("write_tmo", F7_VSUB, 32'd2, 0, 1, TMO + 1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [7];
        logic [6:0] f;
        ops[0] = F7_VLD;  ops[1] = F7_VADD; ops[2] = F7_VSUB; ops[3] = F7_VMUL;
        ops[4] = 7'h03;   ops[5] = 7'h7F;   ops[6] = 7'h21;
        for (int n = 0; n < 40; n++) begin
            f = ops[$urandom_range(0, 6)];
            run_op("rand", f, 32'($urandom_range(0, 12)),
                   $urandom_range(1, TMO + 1), $urandom_range(1, TMO + 1),
                   $urandom_range(1, TMO + 1), 1'($urandom));
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        vec_valid = 1'b1; funct7 = F7_VADD; vlr = 32'd3;
        vls_done = 1'b0; vrb_done = 1'b1; vrw_done = 1'b0;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (vrw_ena === 1'b1) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_reach_write vrw_ena got=0 exp=1 within 20 cycles");
        end
        #2;
        vec_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 17'h0 || valu_sel !== 3'd0) begin
            failures++;
            $display("FAIL rst_async outputs got=%h sel=%0d exp=0", obs, valu_sel);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            vrw_done = 1'b1; vrb_done = 1'b1; vls_done = 1'b1;
            @(negedge clk);
            checks++;
            if (obs !== 17'h0) begin
                failures++;
                $display("FAIL rst_stray_done cyc%0d outputs got=%h exp=0", n, obs);
            end
            @(posedge clk);
            #1;
        end
        vrw_done = 1'b0; vrb_done = 1'b0; vls_done = 1'b0;
        $display("op async_reset");
        run_op("after_reset", F7_VSUB, 32'd6, 0, 2, 2, 1'b1);
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_mul_clamp();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout sim time exceeded limit");
        $fatal(1, "simulation time limit");
    end

endmodule
